// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-port to stream adapter.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    // Request FSM: HOLD covers the cycle after an issue, when the FIFO empty flag is stale.
    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_HOLD = 1'b1
    } req_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = 2;

    // True when one more response can land without overflowing the skid buffer.
    function automatic logic room_for_req(input logic [OCC_W-1:0] occ, input logic outst);
        return ({1'b0, occ} + {2'b00, outst}) < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundle of FIFO read-port and output-stream signals for fifo_rd_stream.
// Latency: none (wiring only).
// Backpressure: m_ready from the sink; FIFO side is request/response.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    import fifo_pkg::*;

    logic             fifo_empty;
    logic             fifo_rd_valid;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_ready;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] word_count;
    logic             err;

    // Adapter side.
    modport slave (
        input  fifo_empty, fifo_rd_data, fifo_rd_ready, m_ready,
        output fifo_rd_valid, m_valid, m_data, occupancy, word_count, err
    );

    // FIFO + sink side (environment).
    modport master (
        output fifo_empty, fifo_rd_data, fifo_rd_ready, m_ready,
        input  fifo_rd_valid, m_valid, m_data, occupancy, word_count, err
    );
endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry in-order skid buffer; head_data is always the oldest word.
// Latency: push visible on head_data/count the cycle after the push.
// Backpressure: pop ignored when empty; push dropped when full without pop.
module skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] count
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;

    // Next-state for entries and count; pop+push keeps the count and shifts in order.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (pop && (cnt_q != '0)) begin
            if (push) begin
                if (cnt_q == OCC_W'(1)) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end else begin
                e0_d  = e1_q;
                cnt_d = cnt_q - OCC_W'(1);
            end
        end else if (push && (cnt_q < OCC_W'(SKID_DEPTH))) begin
            if (cnt_q == '0) begin
                e0_d = push_data;
            end else begin
                e1_d = push_data;
            end
            cnt_d = cnt_q + OCC_W'(1);
        end
    end

    // Entry and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_data = e0_q;
    assign count     = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO request / 1-cycle-response read port into a valid/ready stream.
// Latency: request cycle N -> m_valid at N+2; at most one request every 2 cycles.
// Backpressure: m_ready low fills the 2-entry skid buffer, then requests stop.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    fifo_rd_stream_if.slave  bus
);

    req_state_t       state_q, state_d;
    logic             outst_q, outst_d;
    logic             first_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issue, capture, pop;
    logic [OCC_W-1:0] occ;
    logic [WIDTH-1:0] head;

    // Issue/capture/pop decisions and next-state for error flag and counter.
    // issue is combinational on fifo_empty: the flag must be fresh when the request goes out.
    always_comb begin
        issue   = !rst && !bus.fifo_empty && (state_q == REQ_IDLE) && room_for_req(occ, outst_q);
        capture = outst_q && bus.fifo_rd_ready;
        pop     = (occ != '0) && bus.m_ready;
        state_d = issue ? REQ_HOLD : REQ_IDLE;
        outst_d = issue;
        // A response right after reset belongs to a pre-reset request: ignore it.
        err_d   = err_q
                | (bus.fifo_rd_ready && !outst_q && !first_q)
                | (outst_q && !bus.fifo_rd_ready);
        cnt_d   = pop ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Request FSM and outstanding-response bit.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q <= REQ_IDLE;
            outst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
        end
    end

    // Sticky error, delivered-word counter and post-reset marker.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            first_q <= 1'b0;
        end
    end

    skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk       (rd_clk),
        .rst       (rst),
        .push      (capture && !first_q),
        .push_data (bus.fifo_rd_data),
        .pop       (pop),
        .head_data (head),
        .count     (occ)
    );

    assign bus.fifo_rd_valid = issue;
    assign bus.m_valid       = (occ != '0);
    assign bus.m_data        = head;
    assign bus.occupancy     = occ;
    assign bus.word_count    = cnt_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read port.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: m_ready driven per scenario.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    logic rd_clk = 1'b0;
    logic rst    = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] fq[$];
    bit   model_en = 1'b0;

    fifo_rd_stream_if #(.WIDTH(4), .CNT_W(16)) bus ();

    fifo_rd_stream #(.WIDTH(4), .CNT_W(16)) dut (
        .rd_clk (rd_clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial forever #5 rd_clk = ~rd_clk;

    // One clock: sample the request mid-cycle, then let the FIFO model answer after the edge.
    task automatic tick();
        logic req;
        #3;
        req = bus.fifo_rd_valid;
        @(posedge rd_clk);
        #1;
        if (model_en) begin
            bus.fifo_rd_ready = req;
            if (req && fq.size() > 0) bus.fifo_rd_data = fq.pop_front();
            bus.fifo_empty = (fq.size() == 0);
        end
        #1;
    endtask

    task automatic model_on();
        model_en          = 1'b1;
        bus.fifo_rd_ready = 1'b0;
        bus.fifo_empty    = (fq.size() == 0);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        model_en          = 1'b0;
        fq.delete();
        bus.fifo_empty    = 1'b1;
        bus.fifo_rd_ready = 1'b0;
        bus.fifo_rd_data  = '0;
        bus.m_ready       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (bus.fifo_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0h exp=0", bus.fifo_rd_valid); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0h exp=0", bus.m_valid); end
        checks++; if (bus.m_data !== 4'h0) begin failures++; $display("FAIL reset_m_data got=%0h exp=0", bus.m_data); end
        checks++; if (bus.occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.word_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.word_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.err); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        fq.push_back(4'hA);
        bus.m_ready = 1'b1;
        model_on();
        checks++; if (bus.fifo_rd_valid !== 1'b1) begin failures++; $display("FAIL single_req_c0 got=%0h exp=1", bus.fifo_rd_valid); end
        tick();
        checks++; if (bus.fifo_rd_valid !== 1'b0) begin failures++; $display("FAIL single_req_c1 got=%0h exp=0", bus.fifo_rd_valid); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_mvalid_c1 got=%0h exp=0", bus.m_valid); end
        tick();
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL single_mvalid_c2 got=%0h exp=1", bus.m_valid); end
        checks++; if (bus.m_data !== 4'hA) begin failures++; $display("FAIL single_mdata_c2 got=%0h exp=a", bus.m_data); end
        tick();
        checks++; if (bus.word_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.word_count); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_mvalid_c3 got=%0h exp=0", bus.m_valid); end
    endtask

    task automatic test_stream();
        int nreq = 0;
        int consec = 0;
        bit prev = 1'b0;
        int reqcyc[$];
        logic [3:0] got[$];
        do_reset();
        for (int i = 1; i <= 8; i++) fq.push_back(4'(i));
        bus.m_ready = 1'b1;
        model_on();
        for (int c = 0; c < 40; c++) begin
            if (bus.fifo_rd_valid) begin
                nreq++;
                reqcyc.push_back(c);
                if (prev) consec++;
            end
            prev = bus.fifo_rd_valid;
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
            tick();
        end
        checks++; if (nreq !== 8) begin failures++; $display("FAIL stream_nreq got=%0d exp=8", nreq); end
        checks++; if (consec !== 0) begin failures++; $display("FAIL stream_consecutive got=%0d exp=0", consec); end
        for (int k = 0; k < reqcyc.size() && k < 8; k++) begin
            checks++; if (reqcyc[k] !== 2 * k) begin failures++; $display("FAIL stream_reqcyc[%0d] got=%0d exp=%0d", k, reqcyc[k], 2 * k); end
        end
        checks++; if (got.size() !== 8) begin failures++; $display("FAIL stream_nwords got=%0d exp=8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            checks++; if (got[k] !== 4'(k + 1)) begin failures++; $display("FAIL stream_word[%0d] got=%0h exp=%0h", k, got[k], k + 1); end
        end
        checks++; if (bus.word_count !== 16'd8) begin failures++; $display("FAIL stream_count got=%0d exp=8", bus.word_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL stream_err got=%0h exp=0", bus.err); end
    endtask

    task automatic test_backpressure();
        int extra = 0;
        int held_bad = 0;
        logic [3:0] exp_w[5];
        logic [3:0] got[$];
        exp_w = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        do_reset();
        for (int i = 0; i < 5; i++) fq.push_back(exp_w[i]);
        bus.m_ready = 1'b0;
        model_on();
        repeat (6) tick();
        checks++; if (bus.occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ got=%0d exp=2", bus.occupancy); end
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_mvalid got=%0h exp=1", bus.m_valid); end
        checks++; if (bus.m_data !== 4'hB) begin failures++; $display("FAIL bp_mdata got=%0h exp=b", bus.m_data); end
        repeat (6) begin
            if (bus.fifo_rd_valid) extra++;
            if (bus.m_data !== 4'hB) held_bad++;
            tick();
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL bp_no_req got=%0d exp=0", extra); end
        checks++; if (held_bad !== 0) begin failures++; $display("FAIL bp_held got=%0d exp=0", held_bad); end
        bus.m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
            tick();
        end
        checks++; if (got.size() !== 5) begin failures++; $display("FAIL bp_nwords got=%0d exp=5", got.size()); end
        for (int k = 0; k < got.size() && k < 5; k++) begin
            checks++; if (got[k] !== exp_w[k]) begin failures++; $display("FAIL bp_word[%0d] got=%0h exp=%0h", k, got[k], exp_w[k]); end
        end
        checks++; if (bus.word_count !== 16'd5) begin failures++; $display("FAIL bp_count got=%0d exp=5", bus.word_count); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] got[$];
        do_reset();
        fq.push_back(4'h3); fq.push_back(4'h4); fq.push_back(4'h5);
        bus.m_ready = 1'b0;
        model_on();
        tick(); tick();
        checks++; if (bus.occupancy !== 2'd1) begin failures++; $display("FAIL sim_occ_c2 got=%0d exp=1", bus.occupancy); end
        checks++; if (bus.fifo_rd_valid !== 1'b1) begin failures++; $display("FAIL sim_req_c2 got=%0h exp=1", bus.fifo_rd_valid); end
        tick();
        bus.m_ready = 1'b1;
        if (bus.m_valid) got.push_back(bus.m_data);
        tick();
        checks++; if (bus.occupancy !== 2'd1) begin failures++; $display("FAIL sim_occ_c4 got=%0d exp=1", bus.occupancy); end
        checks++; if (bus.m_data !== 4'h4) begin failures++; $display("FAIL sim_mdata_c4 got=%0h exp=4", bus.m_data); end
        for (int c = 0; c < 10; c++) begin
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
            tick();
        end
        checks++; if (got.size() !== 3) begin failures++; $display("FAIL sim_nwords got=%0d exp=3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checks++; if (got[k] !== 4'(k + 3)) begin failures++; $display("FAIL sim_word[%0d] got=%0h exp=%0h", k, got[k], k + 3); end
        end
        checks++; if (bus.word_count !== 16'd3) begin failures++; $display("FAIL sim_count got=%0d exp=3", bus.word_count); end
    endtask

    task automatic test_errors();
        do_reset();
        bus.fifo_rd_ready = 1'b1;
        bus.fifo_rd_data  = 4'h9;
        tick();
        bus.fifo_rd_ready = 1'b0;
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_spurious got=%0h exp=1", bus.err); end
        repeat (4) tick();
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0h exp=1", bus.err); end
        checks++; if (bus.occupancy !== 2'd0) begin failures++; $display("FAIL err_spurious_occ got=%0d exp=0", bus.occupancy); end
        do_reset();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0h exp=0", bus.err); end
        bus.fifo_empty = 1'b0;
        #1;
        checks++; if (bus.fifo_rd_valid !== 1'b1) begin failures++; $display("FAIL err_missing_req got=%0h exp=1", bus.fifo_rd_valid); end
        tick();
        bus.fifo_empty = 1'b1;
        tick();
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_missing got=%0h exp=1", bus.err); end
        checks++; if (bus.occupancy !== 2'd0) begin failures++; $display("FAIL err_missing_occ got=%0d exp=0", bus.occupancy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fq.push_back(4'h1); fq.push_back(4'h2); fq.push_back(4'h3); fq.push_back(4'h4);
        bus.m_ready = 1'b0;
        model_on();
        repeat (6) tick();
        checks++; if (bus.occupancy !== 2'd2) begin failures++; $display("FAIL rmid_occ_pre got=%0d exp=2", bus.occupancy); end
        rst = 1'b1;
        tick();
        checks++; if (bus.fifo_rd_valid !== 1'b0) begin failures++; $display("FAIL rmid_rd_valid got=%0h exp=0", bus.fifo_rd_valid); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rmid_m_valid got=%0h exp=0", bus.m_valid); end
        checks++; if (bus.m_data !== 4'h0) begin failures++; $display("FAIL rmid_m_data got=%0h exp=0", bus.m_data); end
        checks++; if (bus.occupancy !== 2'd0) begin failures++; $display("FAIL rmid_occ got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.word_count !== 16'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", bus.word_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%0h exp=0", bus.err); end
        tick(); tick();
        rst      = 1'b0;
        model_en = 1'b0;
        fq.delete();
        bus.fifo_empty    = 1'b1;
        bus.fifo_rd_data  = 4'h7;
        bus.fifo_rd_ready = 1'b1;
        tick();
        bus.fifo_rd_ready = 1'b0;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rmid_late_err got=%0h exp=0", bus.err); end
        checks++; if (bus.occupancy !== 2'd0) begin failures++; $display("FAIL rmid_late_occ got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rmid_late_mvalid got=%0h exp=0", bus.m_valid); end
        tick();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rmid_err_after got=%0h exp=0", bus.err); end
    endtask

    initial begin
        bus.fifo_empty    = 1'b1;
        bus.fifo_rd_ready = 1'b0;
        bus.fifo_rd_data  = '0;
        bus.m_ready       = 1'b0;
        @(posedge rd_clk);
        #2;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
